// File: rtl/tl_arb_pkg.sv
// TileLink opcode constants and beat-count helpers shared by the 2:1 master arbiter.
package tl_arb_pkg;

  // A-channel opcodes
  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_ARITH       = 3'd2;
  localparam logic [2:0] OP_LOGIC       = 3'd3;
  localparam logic [2:0] OP_GET         = 3'd4;
  localparam logic [2:0] OP_HINT        = 3'd5;

  // D-channel opcodes
  localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] OP_HINT_ACK        = 3'd2;

  // Beat counter width and log2 of bytes carried per beat
  localparam int unsigned BEAT_W     = 16;
  localparam logic [7:0]  BEAT_SHIFT = 8'd3;

  // Beats in an A message: only data-carrying opcodes (0..3) above one beat of payload burst.
  function automatic logic [BEAT_W-1:0] a_beats(input logic [2:0] opcode, input logic [7:0] size);
    logic [BEAT_W-1:0] beats;
    beats = BEAT_W'(1);
    if ((opcode <= OP_LOGIC) && (size > BEAT_SHIFT)) begin
      beats = BEAT_W'(1) << (size - BEAT_SHIFT);
    end
    return beats;
  endfunction

  // Beats in a D message: only AccessAckData carries a multi-beat payload.
  function automatic logic [BEAT_W-1:0] d_beats(input logic [2:0] opcode, input logic [7:0] size);
    logic [BEAT_W-1:0] beats;
    beats = BEAT_W'(1);
    if ((opcode == OP_ACCESS_ACK_DATA) && (size > BEAT_SHIFT)) begin
      beats = BEAT_W'(1) << (size - BEAT_SHIFT);
    end
    return beats;
  endfunction

endpackage

// File: rtl/tl_master_arb_if.sv
// TileLink-UL A/D channel bundle; master drives A and sinks D, slave is the opposite side.
interface tl_master_arb_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned SIZE_W = 4,
  parameter int unsigned SRC_W  = 1,
  parameter int unsigned SINK_W = 1
);

  logic                a_valid;
  logic                a_ready;
  logic [2:0]          a_opcode;
  logic [2:0]          a_param;
  logic [SIZE_W-1:0]   a_size;
  logic [SRC_W-1:0]    a_source;
  logic [ADDR_W-1:0]   a_address;
  logic [DATA_W/8-1:0] a_mask;
  logic [DATA_W-1:0]   a_data;
  logic                a_corrupt;

  logic                d_valid;
  logic                d_ready;
  logic [2:0]          d_opcode;
  logic [1:0]          d_param;
  logic [SIZE_W-1:0]   d_size;
  logic [SRC_W-1:0]    d_source;
  logic [SINK_W-1:0]   d_sink;
  logic                d_denied;
  logic [DATA_W-1:0]   d_data;
  logic                d_corrupt;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
    input  a_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
    output d_ready
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
    output a_ready,
    output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
    input  d_ready
  );

endinterface

// File: rtl/tl_beat_counter.sv
// Tracks the beat position inside a TileLink burst; first/last are combinational flags.
module tl_beat_counter
  import tl_arb_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              fire,
  input  logic [BEAT_W-1:0] beats,
  output logic              first_c,
  output logic              last_c
);

  logic [BEAT_W-1:0] count_q;

  assign first_c = (count_q == '0);
  assign last_c  = (count_q == (beats - BEAT_W'(1)));

  // Advance on each fired beat, wrap to zero after the last one
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else if (fire) begin
      count_q <= last_c ? '0 : (count_q + BEAT_W'(1));
    end
  end

endmodule

// File: rtl/tl_master_arb.sv
// Two-requester TileLink-UL arbiter onto one master port: zero-latency A muxing with
// burst locking, D routing by source MSB, per-requester outstanding limits.
// Build option: TL_MASTER_ARB_PRIO_EN gives req0 fixed priority instead of round-robin.
module tl_master_arb
  import tl_arb_pkg::*;
#(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned SIZE_W  = 4,
  parameter int unsigned SRC_W   = 1,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic           clock,
  input  logic           reset,
  tl_master_arb_if.slave  req0,
  tl_master_arb_if.slave  req1,
  tl_master_arb_if.master tl_master
);

  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [0:0]       state_q, state_d;
  logic             grant_q, grant_d;
  logic             hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  logic [1:0]        a_req_c;
  logic [1:0]        elig_c;
  logic              arb_gnt_c;
  logic              arb_vld_c;
  logic              locked_c;
  logic              gnt_c;
  logic              sel_vld_c;
  logic              a_fire_c;
  logic              a_first_c;
  logic              a_last_c;
  logic [BEAT_W-1:0] a_beats_c;

  logic [2:0]          a_opcode_c;
  logic [SIZE_W-1:0]   a_size_c;
  logic [SRC_W-1:0]    a_source_c;
  logic [ADDR_W-1:0]   a_address_c;
  logic [DATA_W-1:0]   a_data_c;

  logic              d_route_c;
  logic              d_ready_c;
  logic              d_fire_c;
  logic              d_last_c;
  logic              d_first_unused;
  logic [BEAT_W-1:0] d_beats_c;

  // Requesters that may win a fresh grant: valid and below the outstanding limit
  assign a_req_c = {req1.a_valid, req0.a_valid};
  assign elig_c[0] = a_req_c[0] & (cnt_q[0] != CNT_W'(MAX_OUT));
  assign elig_c[1] = a_req_c[1] & (cnt_q[1] != CNT_W'(MAX_OUT));

`ifdef TL_MASTER_ARB_PRIO_EN
  // Fixed priority: req0 wins whenever it is eligible
  always_comb begin
    arb_vld_c = |elig_c;
    arb_gnt_c = ~elig_c[0];
  end
`else
  logic rr_q, rr_d;

  // Round-robin: the pointer names the requester favoured this cycle
  always_comb begin
    arb_vld_c = |elig_c;
    arb_gnt_c = elig_c[rr_q] ? rr_q : ~rr_q;
  end

  // Pointer moves past the winner whenever a new message starts
  always_comb begin
    rr_d = rr_q;
    if (a_fire_c && a_first_c) begin
      rr_d = ~gnt_c;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  // Grant is frozen during a burst and while a presented beat is stalled
  assign locked_c  = (state_q == ST_LOCK) | hold_q;
  assign gnt_c     = locked_c ? grant_q : arb_gnt_c;
  assign sel_vld_c = locked_c ? a_req_c[grant_q] : arb_vld_c;
  assign a_fire_c  = ~reset & sel_vld_c & tl_master.a_ready;

  assign a_opcode_c  = gnt_c ? req1.a_opcode  : req0.a_opcode;
  assign a_size_c    = gnt_c ? req1.a_size    : req0.a_size;
  assign a_source_c  = gnt_c ? req1.a_source  : req0.a_source;
  assign a_address_c = gnt_c ? req1.a_address : req0.a_address;
  assign a_data_c    = gnt_c ? req1.a_data    : req0.a_data;

  assign tl_master.a_valid   = ~reset & sel_vld_c;
  assign tl_master.a_opcode  = a_opcode_c;
  assign tl_master.a_param   = gnt_c ? req1.a_param   : req0.a_param;
  assign tl_master.a_size    = a_size_c;
  assign tl_master.a_source  = {gnt_c, a_source_c};
  assign tl_master.a_address = a_address_c;
  assign tl_master.a_mask    = gnt_c ? req1.a_mask    : req0.a_mask;
  assign tl_master.a_data    = a_data_c;
  assign tl_master.a_corrupt = gnt_c ? req1.a_corrupt : req0.a_corrupt;

  assign req0.a_ready = ~reset & sel_vld_c & ~gnt_c & tl_master.a_ready;
  assign req1.a_ready = ~reset & sel_vld_c &  gnt_c & tl_master.a_ready;

  assign a_beats_c = a_beats(a_opcode_c, 8'(a_size_c));

  tl_beat_counter u_a_beats (
    .clock   (clock),
    .reset   (reset),
    .fire    (a_fire_c),
    .beats   (a_beats_c),
    .first_c (a_first_c),
    .last_c  (a_last_c)
  );

  // D responses are steered by the source MSB the arbiter prepended on A
  assign d_route_c = tl_master.d_source[SRC_W];
  assign d_ready_c = d_route_c ? req1.d_ready : req0.d_ready;
  assign d_fire_c  = ~reset & tl_master.d_valid & d_ready_c;
  assign d_beats_c = d_beats(tl_master.d_opcode, 8'(tl_master.d_size));

  assign tl_master.d_ready = ~reset & d_ready_c;

  assign req0.d_valid   = ~reset & tl_master.d_valid & ~d_route_c;
  assign req0.d_opcode  = tl_master.d_opcode;
  assign req0.d_param   = tl_master.d_param;
  assign req0.d_size    = tl_master.d_size;
  assign req0.d_source  = tl_master.d_source[SRC_W-1:0];
  assign req0.d_sink    = tl_master.d_sink;
  assign req0.d_denied  = tl_master.d_denied;
  assign req0.d_data    = tl_master.d_data;
  assign req0.d_corrupt = tl_master.d_corrupt;

  assign req1.d_valid   = ~reset & tl_master.d_valid & d_route_c;
  assign req1.d_opcode  = tl_master.d_opcode;
  assign req1.d_param   = tl_master.d_param;
  assign req1.d_size    = tl_master.d_size;
  assign req1.d_source  = tl_master.d_source[SRC_W-1:0];
  assign req1.d_sink    = tl_master.d_sink;
  assign req1.d_denied  = tl_master.d_denied;
  assign req1.d_data    = tl_master.d_data;
  assign req1.d_corrupt = tl_master.d_corrupt;

  tl_beat_counter u_d_beats (
    .clock   (clock),
    .reset   (reset),
    .fire    (d_fire_c),
    .beats   (d_beats_c),
    .first_c (d_first_unused),
    .last_c  (d_last_c)
  );

  // IDLE/LOCK next state plus grant capture for bursts and stalled beats
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    hold_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        grant_d = gnt_c;
        hold_d  = sel_vld_c & ~tl_master.a_ready;
        if (a_fire_c && a_first_c && !a_last_c) begin
          state_d = ST_LOCK;
        end
      end
      ST_LOCK: begin
        if (a_fire_c && a_last_c) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outstanding counts: +1 on a message's first A beat, -1 on its last D beat, floor at zero
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      logic inc;
      logic dec;
      inc = a_fire_c & a_first_c & (gnt_c == 1'(i));
      dec = d_fire_c & d_last_c & (d_route_c == 1'(i)) & (cnt_q[i] != '0);
      cnt_d[i] = cnt_q[i];
      if (inc && !dec) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec && !inc) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  // State, grant and outstanding-count registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b0;
      hold_q  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      hold_q  <= hold_d;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: doc/tl_master_arb.md
TL_MASTER_ARB -- requirements
Module: tl_master_arb

Interface
REQ-001 SHALL have parameter DATA_W, default 64, TileLink data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter SIZE_W, default 4, size field width.
REQ-004 SHALL have parameter SRC_W, default 1, requester-side source width.
REQ-005 SHALL have parameter MAX_OUT, default 4, maximum outstanding transactions per requester.
REQ-006 SHALL have port clock, input, 1, the single clock for all logic.
REQ-007 SHALL have port reset, input, 1, reset, synchronous and active-high.
REQ-008 SHALL have port group reqN_a_{valid,ready,opcode[3],param[3],size,source,address,mask,data,corrupt} for N=0,1; ready is an output, all others are inputs; these are the requester A channels.
REQ-009 SHALL have port group reqN_d_{valid,ready,opcode[3],param[2],size,source,sink,denied,data,corrupt} for N=0,1; ready is an input, all others are outputs; these are the requester D channels.
REQ-010 SHALL have port group tl_master_a_*, output except a_ready; same fields as reqN_a; source width SRC_W+1.
REQ-011 SHALL have port group tl_master_d_*, input except d_ready; same fields as reqN_d; source width SRC_W+1.

Function
REQ-012 SHALL forward the granted requester's A bits to tl_master_a_*, with source = {N, reqN_a_source}.
REQ-013 SHALL implement A beat count: beats = 1 when size<=3 or opcode=Get(4); otherwise 2^(size-3) for opcodes 0..3.
REQ-014 SHALL implement a two-state FSM:
  - IDLE: arbitrate among valid, non-full requesters.
  - LOCK: entered when a multi-beat first beat fires; the grant is held until the last beat fires, then returns to IDLE.
REQ-015 SHALL, in IDLE, present the grant combinationally in the same cycle; A path latency is 0 cycles, with no buffering.
REQ-016 SHALL drive reqN_a_ready = granted & tl_master_a_ready; a non-granted ready SHALL be 0.
REQ-017 SHALL never change the grant while tl_master_a_valid=1 and a_ready=0 (no withdrawal mid-handshake).
REQ-018 SHALL route D by tl_master_d_source MSB: reqN_d_valid = d_valid & (MSB==N); d_source is stripped to SRC_W bits.
REQ-019 SHALL drive tl_master_d_ready = reqN_d_ready of the addressed requester.
REQ-020 SHALL compute D beat count: AccessAckData(1) uses 2^(size-3) beats when size>3; else 1.
REQ-021 SHALL keep per-requester outstanding counters:
  - increment on the first A beat fire;
  - decrement on the last D beat fire;
  - simultaneous increment and decrement leaves the count unchanged.
REQ-022 SHALL treat a requester with count==MAX_OUT as ineligible for grant.
REQ-023 SHALL ignore a D beat arriving with count==0: it is still routed, and the count saturates at 0.
REQ-024 SHALL use a 1-bit round-robin pointer, advancing past the winner at each first-beat fire.

Reset
REQ-025 SHALL, on reset, set FSM=IDLE, rr pointer=0, all counters=0, and beat counters=0.
REQ-026 SHALL hold all *_valid and *_ready outputs at 0 while reset=1.
REQ-027 SHALL abandon a burst in progress on reset mid-burst, with no completion beats issued.

Configuration
REQ-028 SHALL, with TL_MASTER_ARB_PRIO_EN defined, give req0 fixed priority in IDLE; the rr pointer is removed.
REQ-029 SHALL, without TL_MASTER_ARB_PRIO_EN, use round-robin arbitration per REQ-024.

Structure
REQ-030 SHALL place TL opcode localparams and beat-count functions in package tl_arb_pkg.
REQ-031 SHALL implement one sub-module, tl_beat_counter, instantiated for the A side and the D side.

Verification
REQ-032 SHALL cover: both requesters assert Get size=3 every cycle -> grants alternate 0,1,0,1; master source MSB follows.
REQ-033 SHALL cover: req1 sends PutFullData size=5 while req0 is valid -> 4 req1 beats are contiguous, then req0 is granted.
REQ-034 SHALL cover: req0 issues 4 Gets with no D -> the 5th is blocked (req0_a_ready=0) while req1 is still granted.
REQ-035 SHALL cover: AccessAckData size=5 with source MSB=1 -> 4 beats appear on req1_d; req1 count decrements only after the 4th.
REQ-036 SHALL cover: a first-beat A fire and a last-beat D fire for req0 in the same cycle -> count unchanged.
REQ-037 SHALL cover: reset asserted on beat 2 of 4 -> next cycle is IDLE with counters 0 and outputs valid=0.
